// File: rtl/cmp_sync_pkg.sv
// Shared constants for the CMP sync pulse generator.
// Holds ratio width, minimum legal ratio and reset ratios.
package cmp_sync_pkg;

   localparam int RATIO_W        = 5;
   localparam int RATIO_MIN      = 2;
   localparam int JBUS_RATIO_DEF = 4;
   localparam int DRAM_RATIO_DEF = 4;

endpackage

// File: rtl/cmp_sync_div_ctr.sv
// One slow-domain divider: counter, active/shadow ratio,
// pending flag, request clamp and registered rx/tx decode.
module cmp_sync_div_ctr #(
   parameter int RATIO_W   = cmp_sync_pkg::RATIO_W,
   parameter int RATIO_RST = cmp_sync_pkg::JBUS_RATIO_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gen_en,
   input  logic               cap,
   input  logic [RATIO_W-1:0] req_ratio,
   output logic               rx,
   output logic               tx,
   output logic               pend
);

   import cmp_sync_pkg::*;

   localparam logic [RATIO_W-1:0] R_MIN = RATIO_W'(RATIO_MIN);
   localparam logic [RATIO_W-1:0] R_RST = RATIO_W'(RATIO_RST);
   localparam logic [RATIO_W-1:0] ONE   = RATIO_W'(1);

   logic [RATIO_W-1:0] cnt;
   logic [RATIO_W-1:0] ratio;
   logic [RATIO_W-1:0] shadow;
   logic [RATIO_W-1:0] req_clamped;
   logic [RATIO_W-1:0] last;
   logic               wrap;

   assign req_clamped = (req_ratio < R_MIN) ? R_MIN : req_ratio;
   assign last        = ratio - ONE;
   assign wrap        = (cnt == last);

   // count, decode pulses, and swap in the shadow ratio at a boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         ratio  <= R_RST;
         shadow <= R_RST;
         pend   <= 1'b0;
         rx     <= 1'b0;
         tx     <= 1'b0;
      end else begin
         if (gen_en) begin
            rx  <= (cnt == '0);
            tx  <= wrap;
            cnt <= wrap ? '0 : cnt + ONE;
            if (pend && wrap) begin
               ratio <= shadow;
               pend  <= 1'b0;
            end
         end else begin
            cnt <= '0;
            rx  <= 1'b0;
            tx  <= 1'b0;
            if (pend) begin
               ratio <= shadow;
               pend  <= 1'b0;
            end
         end
         if (cap) begin
            shadow <= req_clamped;
            pend   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmp_sync_pulse_gen.sv
// CMP-domain generator of the JBUS/DRAM global sync pulses.
// Optional DRAM domain is built when CMP_SYNC_DRAM_EN is defined.
module cmp_sync_pulse_gen #(
   parameter int RATIO_W        = cmp_sync_pkg::RATIO_W,
   parameter int JBUS_RATIO_RST = cmp_sync_pkg::JBUS_RATIO_DEF,
   parameter int DRAM_RATIO_RST = cmp_sync_pkg::DRAM_RATIO_DEF
) (
   input  logic               cmp_gclk,
   input  logic               cmp_arst,
   input  logic               gen_en,
   input  logic               cfg_vld,
   input  logic [RATIO_W-1:0] cfg_jbus_ratio,
   input  logic [RATIO_W-1:0] cfg_dram_ratio,
   output logic               cfg_ack,
   output logic               jbus_rx_sync_global,
   output logic               jbus_tx_sync_global,
   output logic               dram_rx_sync_global,
   output logic               dram_tx_sync_global
);

   import cmp_sync_pkg::*;

   logic jbus_pend;
   logic dram_pend;
   logic any_pend;
   logic any_pend_q;
   logic cap;

   assign any_pend = jbus_pend | dram_pend;

   // a held request is taken once; the ack window blocks re-capture
   assign cap = cfg_vld & ~any_pend & ~any_pend_q & ~cfg_ack;

   cmp_sync_div_ctr #(
      .RATIO_W   (RATIO_W),
      .RATIO_RST (JBUS_RATIO_RST)
   ) u_jbus (
      .clk       (cmp_gclk),
      .rst       (cmp_arst),
      .gen_en    (gen_en),
      .cap       (cap),
      .req_ratio (cfg_jbus_ratio),
      .rx        (jbus_rx_sync_global),
      .tx        (jbus_tx_sync_global),
      .pend      (jbus_pend)
   );

`ifdef CMP_SYNC_DRAM_EN
   cmp_sync_div_ctr #(
      .RATIO_W   (RATIO_W),
      .RATIO_RST (DRAM_RATIO_RST)
   ) u_dram (
      .clk       (cmp_gclk),
      .rst       (cmp_arst),
      .gen_en    (gen_en),
      .cap       (cap),
      .req_ratio (cfg_dram_ratio),
      .rx        (dram_rx_sync_global),
      .tx        (dram_tx_sync_global),
      .pend      (dram_pend)
   );
`else
   logic unused_dram;
   assign unused_dram         = ^cfg_dram_ratio;
   assign dram_pend           = 1'b0;
   assign dram_rx_sync_global = 1'b0;
   assign dram_tx_sync_global = 1'b0;
`endif

   // ack one cycle after the edge where the last pending domain cleared
   always_ff @(posedge cmp_gclk or posedge cmp_arst) begin
      if (cmp_arst) begin
         any_pend_q <= 1'b0;
         cfg_ack    <= 1'b0;
      end else begin
         any_pend_q <= any_pend;
         cfg_ack    <= any_pend_q & ~any_pend;
      end
   end

endmodule

// File: tb/tb_cmp_sync_pulse_gen.sv
// Randomised scoreboard bench for cmp_sync_pulse_gen.
// Reference model works in period phase (edge - period start) mod R.
`timescale 1ns/1ps
module tb_cmp_sync_pulse_gen;

   localparam int RW = 5;
`ifdef CMP_SYNC_DRAM_EN
   localparam int ND = 2;
`else
   localparam int ND = 1;
`endif

   logic          cmp_gclk = 1'b0;
   logic          cmp_arst = 1'b1;
   logic          gen_en = 1'b0;
   logic          cfg_vld = 1'b0;
   logic [RW-1:0] cfg_jbus_ratio = '0;
   logic [RW-1:0] cfg_dram_ratio = '0;
   logic          cfg_ack;
   logic          jrx, jtx, drx, dtx;

   int checks = 0;
   int errors = 0;

   always #5 cmp_gclk = ~cmp_gclk;

   cmp_sync_pulse_gen dut (
      .cmp_gclk            (cmp_gclk),
      .cmp_arst            (cmp_arst),
      .gen_en              (gen_en),
      .cfg_vld             (cfg_vld),
      .cfg_jbus_ratio      (cfg_jbus_ratio),
      .cfg_dram_ratio      (cfg_dram_ratio),
      .cfg_ack             (cfg_ack),
      .jbus_rx_sync_global (jrx),
      .jbus_tx_sync_global (jtx),
      .dram_rx_sync_global (drx),
      .dram_tx_sync_global (dtx)
   );

   // reference model state
   int        ratio [2];
   int        shadow [2];
   longint    t0 [2];
   bit        pend [2];
   bit        run [2];
   bit        served;
   longint    k = 0;
   longint    ack_edge = -1;
   bit [4:0]  exp_q [$];

   function automatic int clamp(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   // model: push the expected output vector for every edge
   always @(posedge cmp_gclk or posedge cmp_arst) begin
      bit [1:0] rx, tx;
      bit       any_old, cleared, ackv;
      longint   ph;
      if (cmp_arst) begin
         for (int d = 0; d < 2; d++) begin
            ratio[d] = 4;
            shadow[d] = 4;
            pend[d] = 0;
            run[d] = 0;
         end
         served = 0;
         ack_edge = -1;
         exp_q.push_back(5'b0);
      end else begin
         rx = '0;
         tx = '0;
         cleared = 0;
         any_old = pend[0] | pend[1];
         for (int d = 0; d < ND; d++) begin
            if (gen_en) begin
               if (!run[d]) begin
                  run[d] = 1;
                  t0[d] = k;
               end
               ph = (k - t0[d]) % ratio[d];
               rx[d] = (ph == 0);
               tx[d] = (ph == ratio[d] - 1);
               if (pend[d] && tx[d]) begin
                  ratio[d] = shadow[d];
                  t0[d] = k + 1;
                  pend[d] = 0;
                  cleared = 1;
               end
            end else begin
               run[d] = 0;
               if (pend[d]) begin
                  ratio[d] = shadow[d];
                  pend[d] = 0;
                  cleared = 1;
               end
            end
         end
         ackv = (k == ack_edge);
         if (cleared && !(pend[0] | pend[1])) begin
            ack_edge = k + 1;
            served = 1;
         end
         if (!cfg_vld) served = 0;
         else if (!any_old && !served) begin
            shadow[0] = clamp(int'(cfg_jbus_ratio));
            shadow[1] = clamp(int'(cfg_dram_ratio));
            pend[0] = 1;
            pend[1] = (ND == 2);
         end
         exp_q.push_back({ackv, rx[0], tx[0], rx[1], tx[1]});
         k++;
      end
   end

   // monitor: compare the current DUT outputs against the newest entry
   always @(negedge cmp_gclk) begin
      bit [4:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q[$];
         exp_q.delete();
         a = {cfg_ack, jrx, jtx, drx, dtx};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL sync_out t=%0t ack/jrx/jtx/drx/dtx got %b exp %b",
                     $time, a, e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge cmp_gclk);
      #1;
   endtask

   task automatic start_req(input int j, input int d);
      cfg_jbus_ratio = RW'(j);
      cfg_dram_ratio = RW'(d);
      cfg_vld = 1'b1;
   endtask

   task automatic wait_ack();
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (cfg_ack) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ack_timeout t=%0t got no cfg_ack exp ack within 100",
                  $time);
      end
      cfg_vld = 1'b0;
   endtask

   task automatic request(input int j, input int d);
      start_req(j, d);
      wait_ack();
   endtask

   initial begin
      bit [4:0] a;
      tick(3);
      cmp_arst = 1'b0;
      tick(2);
      // default ratio 4
      gen_en = 1'b1;
      tick(14);
      // ratio change while running
      request(3, 6);
      tick(20);
      // clamp of 0 and 1
      request(0, 1);
      tick(10);
      request(1, 0);
      tick(6);
      // request while stopped
      gen_en = 1'b0;
      tick(2);
      request(7, 5);
      tick(3);
      gen_en = 1'b1;
      tick(20);
      // gen_en drops while pending
      start_req(20, 17);
      tick(3);
      gen_en = 1'b0;
      wait_ack();
      gen_en = 1'b1;
      tick(25);
      // async reset with a request pending
      start_req(9, 9);
      tick(2);
      #2 cmp_arst = 1'b1;
      #1;
      a = {cfg_ack, jrx, jtx, drx, dtx};
      checks++;
      if (a !== 5'b0) begin
         errors++;
         $display("FAIL arst_clear t=%0t got %b exp 00000", $time, a);
      end
      cfg_vld = 1'b0;
      tick(2);
      cmp_arst = 1'b0;
      tick(20);
      // random traffic
      repeat (60) begin
         case ($urandom_range(0, 3))
            0: gen_en = ~gen_en;
            1, 2: request($urandom_range(0, 31), $urandom_range(0, 31));
            default: tick($urandom_range(1, 30));
         endcase
         tick(1);
      end
      tick(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
